// File: rtl/tcs3200_rgb_meter.sv
// TCS3200 colour sensor front end: steps the S2/S3 filter through red, green and blue and counts OUT edges per gate.
// Optional macro COLOR_AVG_EN: each published value becomes the mean of the previous output and the new frame.
module tcs3200_rgb_meter #(
  parameter int GATE_CYCLES   = 500000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CNT_W         = 16,
  parameter int NORM_SHIFT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sensor_out,
  output logic        s2,
  output logic        s3,
  output logic [15:0] red_norm,
  output logic [15:0] green_norm,
  output logic [15:0] blue_norm,
  output logic        valid,
  output logic        busy
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, STORE, DONE} state_t;

  state_t           state, next_state;
  logic [1:0]       ch, next_ch;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;
  logic             sync_a, sync_b, sync_d;
  logic             rise;
  logic             entering_settle;
  logic [15:0]      store_val;
  logic [15:0]      red_sh, green_sh, blue_sh;

  function automatic logic [1:0] filter_code(input logic [1:0] c);
    case (c)
      2'd1:    return 2'b11;
      2'd2:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

`ifdef COLOR_AVG_EN
  logic first_frame;

  function automatic logic [15:0] blend(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic load);
    logic [16:0] sum;
    sum = {1'b0, old_v} + {1'b0, new_v};
    return load ? new_v : sum[16:1];
  endfunction
`endif

  assign rise            = sync_b & ~sync_d;
  assign busy            = (state != IDLE);
  assign store_val       = 16'(count >> NORM_SHIFT);
  assign entering_settle = (next_state == SETTLE) && (state != SETTLE);

  always_comb begin
    next_state = state;
    next_ch    = ch;
    case (state)
      IDLE: begin
        next_ch = 2'd0;
        if (en) next_state = SETTLE;
      end
      SETTLE: if (timer == SETTLE_LAST) next_state = COUNT;
      COUNT:  if (timer == GATE_LAST) next_state = STORE;
      STORE: begin
        if (ch == 2'd2) begin
          next_state = DONE;
        end else begin
          next_state = SETTLE;
          next_ch    = ch + 2'd1;
        end
      end
      DONE: begin
        next_ch    = 2'd0;
        next_state = en ? SETTLE : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The timer restarts on every state change so SETTLE and COUNT each last exactly their programmed length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= 2'd0;
      timer <= '0;
    end else begin
      state <= next_state;
      ch    <= next_ch;
      if ((state == SETTLE || state == COUNT) && next_state == state) timer <= timer + TW'(1);
      else timer <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      sync_d     <= 1'b0;
      count      <= '0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      red_sh     <= '0;
      green_sh   <= '0;
      blue_sh    <= '0;
      red_norm   <= '0;
      green_norm <= '0;
      blue_norm  <= '0;
      valid      <= 1'b0;
`ifdef COLOR_AVG_EN
      first_frame <= 1'b1;
`endif
    end else begin
      sync_a <= sensor_out;
      sync_b <= sync_a;
      sync_d <= sync_b;
      valid  <= (state == DONE);
      if (entering_settle) {s2, s3} <= filter_code(next_ch);
      // Outside COUNT the counter sits at zero, which also clears it after STORE has captured it.
      if (state == COUNT) begin
        if (rise && count != CNT_MAX) count <= count + CNT_W'(1);
      end else begin
        count <= '0;
      end
      if (state == STORE) begin
        case (ch)
          2'd0:    red_sh   <= store_val;
          2'd1:    green_sh <= store_val;
          default: blue_sh  <= store_val;
        endcase
      end
      if (state == DONE) begin
`ifdef COLOR_AVG_EN
        red_norm    <= blend(red_norm, red_sh, first_frame);
        green_norm  <= blend(green_norm, green_sh, first_frame);
        blue_norm   <= blend(blue_norm, blue_sh, first_frame);
        first_frame <= 1'b0;
`else
        red_norm   <= red_sh;
        green_norm <= green_sh;
        blue_norm  <= blue_sh;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tcs3200_rgb_meter.sv
// Bench for tcs3200_rgb_meter: a frame-timeline model over the recorded OUT pin history, plus directed literal checks.
module tb_tcs3200_rgb_meter;

  localparam int GATE   = 48;
  localparam int SETTLE = 4;
  localparam int CW     = 4;
  localparam int NSHIFT = 1;
  localparam int SPAN   = SETTLE + GATE + 1;
  localparam int LAT    = 3 * SPAN + 1;
  localparam int CMAX   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sensor_out = 1'b0;
  logic        s2, s3, valid, busy;
  logic [15:0] red_norm, green_norm, blue_norm;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int density = 4;
  int tcyc = 0;

  int          cyc = 0;
  bit          hist [0:32767];
  bit          model_ready = 1'b0;
  bit          running = 1'b0;
  int          t0 = 0;
  logic [1:0]  m_code = 2'b00;
  logic [15:0] m_norm [3];
  bit          m_valid = 1'b0;
  bit          m_first = 1'b1;

  tcs3200_rgb_meter #(
    .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CW), .NORM_SHIFT(NSHIFT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_out),
    .s2(s2), .s3(s3),
    .red_norm(red_norm), .green_norm(green_norm), .blue_norm(blue_norm),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Edges seen by the counter at clock m are pin samples m-2 high and m-3 low.
  function automatic int window_norm(input int start);
    int n;
    n = 0;
    for (int m = start; m < start + GATE; m++)
      if (hist[m-2] && !hist[m-3]) n++;
    if (n > CMAX) n = CMAX;
    return n >> NSHIFT;
  endfunction

  function automatic logic periodic(input int per);
    return ((tcyc / (per / 2)) % 2) == 1;
  endfunction

  // Frame timeline: a frame starting at clock t0 has channel c counting over clocks t0+c*SPAN+SETTLE+1 .. +GATE.
  initial begin
    int ph, nv;
    forever begin
      @(posedge clk);
      cyc++;
      hist[cyc] = sensor_out;
      if (rst) begin
        hist[cyc] = 1'b0;
        hist[cyc-1] = 1'b0;
        if (cyc >= 2) hist[cyc-2] = 1'b0;
        running = 1'b0;
        m_code = 2'b00;
        m_valid = 1'b0;
        m_first = 1'b1;
        for (int i = 0; i < 3; i++) m_norm[i] = 16'd0;
        model_ready = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (!running) begin
          if (en) begin
            running = 1'b1;
            t0 = cyc;
            m_code = 2'b00;
          end
        end else begin
          ph = cyc - t0;
          if (ph == SPAN) m_code = 2'b11;
          else if (ph == 2 * SPAN) m_code = 2'b01;
          else if (ph == LAT) begin
            for (int c = 0; c < 3; c++) begin
              nv = window_norm(t0 + c * SPAN + SETTLE + 1);
`ifdef COLOR_AVG_EN
              m_norm[c] = m_first ? 16'(nv) : 16'((int'(m_norm[c]) + nv) / 2);
`else
              m_norm[c] = 16'(nv);
`endif
            end
            m_first = 1'b0;
            m_valid = 1'b1;
            if (en) begin
              t0 = cyc;
              m_code = 2'b00;
            end else begin
              running = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check_output("busy", busy, running);
        check_output("valid", valid, m_valid);
        check_output("filter", {s2, s3}, m_code);
        check_output("red_norm", red_norm, m_norm[0]);
        check_output("green_norm", green_norm, m_norm[1]);
        check_output("blue_norm", blue_norm, m_norm[2]);
      end
    end
  end

  // OUT pin driver: dark, fixed periods per filter, or random density.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcyc++;
      case (mode)
        1: sensor_out = ({s2, s3} == 2'b00) ? periodic(2) : (({s2, s3} == 2'b11) ? periodic(4) : periodic(8));
        2: sensor_out = ($urandom_range(0, 7) < density);
        3: sensor_out = ({s2, s3} == 2'b00) ? periodic(4) : (({s2, s3} == 2'b11) ? periodic(2) : periodic(8));
        default: sensor_out = 1'b0;
      endcase
    end
  end

  task automatic apply_stimulus(input logic new_en);
    @(posedge clk);
    #1 en = new_en;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 1000);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, seen, c00, c11, c01;
    rst = 1'b1;
    en = 1'b0;
    mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_s2", s2, 0);
    check_output("reset_s3", s3, 0);
    check_output("reset_valid", valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_red", red_norm, 0);
    repeat (50) begin
      @(negedge clk);
      check_output("idle_busy", busy, 0);
    end

    // Red saturates (24 edges > 15), green 12 edges, blue 6 edges; all halved.
    mode = 1;
    apply_stimulus(1'b1);
    wait_valid(n);
    check_output("frame1_seen", valid, 1);
    check_output("frame1_latency", n - 2, 160);
    check_output("frame1_red", red_norm, 7);
    check_output("frame1_green", green_norm, 6);
    check_output("frame1_blue", blue_norm, 3);
    mode = 3;
    en = 1'b0;
    @(negedge clk);
    check_output("valid_pulse_width", valid, 0);
    wait_valid(n);
    check_output("frame2_seen", valid, 1);
    check_output("frame2_gap", n + 1, 160);
`ifdef COLOR_AVG_EN
    check_output("frame2_red", red_norm, 6);
    check_output("frame2_green", green_norm, 6);
`else
    check_output("frame2_red", red_norm, 6);
    check_output("frame2_green", green_norm, 7);
`endif
    check_output("frame2_blue", blue_norm, 3);
    check_output("idle_after_en_low", busy, 0);

    // Reset in the middle of the green count window.
    mode = 1;
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s2 && s3) && n < 1000);
    check_output("reached_green", {s2, s3}, 3);
    repeat (SETTLE + 10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_valid", valid, 0);
    check_output("midreset_red", red_norm, 0);
    check_output("midreset_green", green_norm, 0);
    check_output("midreset_filter", {s2, s3}, 0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check_output("no_valid_after_reset", seen, 0);

    // Dark frame with a filter-code census.
    mode = 0;
    c00 = 0; c11 = 0; c01 = 0;
    apply_stimulus(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy && !valid) begin
        if ({s2, s3} == 2'b00) c00++;
        else if ({s2, s3} == 2'b11) c11++;
        else if ({s2, s3} == 2'b01) c01++;
      end
    end while (!valid && n < 1000);
    en = 1'b0;
    check_output("dark_seen", valid, 1);
    check_output("dark_red_cycles", c00, 53);
    check_output("dark_green_cycles", c11, 53);
    check_output("dark_blue_cycles", c01, 54);
    check_output("dark_red", red_norm, 0);
    check_output("dark_blue", blue_norm, 0);

    mode = 2;
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 79) == 0) en = ~en;
      rst = ($urandom_range(0, 1499) == 0);
      if (i % 100 == 0) density = $urandom_range(0, 8);
    end
    rst = 1'b0;
    en = 1'b0;
    repeat (LAT + 10) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
